// File: rtl/uart_pkg.sv
// Shared types and helpers for the single-clock UART: FSM state encodings,
// frame-length clamping and parity computation.
package uart_pkg;

  localparam logic [3:0] LEN_MIN  = 4'd5;
  localparam logic       IDLE_LVL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK_WAIT
  } rx_state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (len < LEN_MIN) return LEN_MIN;
    if (int'(len) > max_len) return 4'(max_len);
    return len;
  endfunction

  // Expected parity bit over the low len bits of data.
  function automatic logic parity(input logic [15:0] data, input logic [3:0] len, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 16; i++)
      if (i < int'(len)) p = p ^ data[i];
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divisor counter; tick pulses for one cycle on each wrap.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  // >= rather than == so a divisor shrunk below the count still wraps at once.
  assign tick = (cnt_reg >= div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt_reg <= '0;
    else if (tick) cnt_reg <= '0;
    else           cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/uart_core.sv
// Single-clock UART: oversampled TX/RX FSMs, RX holding register with overrun,
// break detection and internal loopback.
module uart_core #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [3:0]        cfg_len,
  input  logic              cfg_par_en,
  input  logic              cfg_par_odd,
  input  logic              cfg_stop2,
  input  logic              cfg_loopback,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rxd,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun
);
  import uart_pkg::*;

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  logic os_tick;

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .div  (cfg_div),
    .tick (os_tick)
  );

  tx_state_t         tx_state_reg;
  logic [OS_W-1:0]   tx_os_reg;
  logic [3:0]        tx_bit_reg, tx_len_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic              tx_par_en_reg, tx_par_reg, tx_stop2_reg, tx_line;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_reg  <= TX_IDLE;
      tx_os_reg     <= '0;
      tx_bit_reg    <= '0;
      tx_len_reg    <= LEN_MIN;
      tx_shift_reg  <= '0;
      tx_par_en_reg <= 1'b0;
      tx_par_reg    <= 1'b0;
      tx_stop2_reg  <= 1'b0;
    end else if (tx_state_reg == TX_IDLE) begin
      if (tx_valid) begin
        tx_state_reg  <= TX_START;
        tx_os_reg     <= '0;
        tx_bit_reg    <= '0;
        tx_len_reg    <= clamp_len(cfg_len, DATA_W);
        tx_shift_reg  <= tx_data;
        tx_par_en_reg <= cfg_par_en;
        tx_par_reg    <= parity(16'(tx_data), clamp_len(cfg_len, DATA_W), cfg_par_odd);
        tx_stop2_reg  <= cfg_stop2;
      end
    end else if (os_tick) begin
      if (tx_os_reg != OS_LAST) begin
        tx_os_reg <= tx_os_reg + 1'b1;
      end else begin
        tx_os_reg <= '0;
        case (tx_state_reg)
          TX_START:  tx_state_reg <= TX_DATA;
          TX_DATA: begin
            tx_shift_reg <= tx_shift_reg >> 1;
            if (tx_bit_reg == tx_len_reg - 4'd1)
              tx_state_reg <= tx_par_en_reg ? TX_PARITY : TX_STOP1;
            else
              tx_bit_reg <= tx_bit_reg + 4'd1;
          end
          TX_PARITY: tx_state_reg <= TX_STOP1;
          TX_STOP1:  tx_state_reg <= tx_stop2_reg ? TX_STOP2 : TX_IDLE;
          default:   tx_state_reg <= TX_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    tx_line = IDLE_LVL;
    case (tx_state_reg)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_shift_reg[0];
      TX_PARITY: tx_line = tx_par_reg;
      default:   tx_line = IDLE_LVL;
    endcase
  end

  assign tx_ready = (tx_state_reg == TX_IDLE);
  assign tx_busy  = ~tx_ready;
  assign txd      = cfg_loopback ? IDLE_LVL : tx_line;

  logic rx_in, rx_meta_reg, rx_sync_reg, rx_prev_reg;

  assign rx_in = cfg_loopback ? tx_line : rxd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= IDLE_LVL;
      rx_sync_reg <= IDLE_LVL;
      rx_prev_reg <= IDLE_LVL;
    end else begin
      rx_meta_reg <= rx_in;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  rx_state_t         rx_state_reg;
  logic [OS_W-1:0]   rx_os_reg;
  logic [3:0]        rx_bit_reg, rx_len_reg;
  logic [DATA_W-1:0] rx_buf_reg, rx_data_reg;
  logic              rx_par_en_reg, rx_par_odd_reg, rx_par_bit_reg;
  logic              rx_valid_reg, rx_perr_reg, rx_ferr_reg, rx_overrun_reg;
  logic              rx_sample;

  // Bit-centre sample point; START uses the half-bit count.
  assign rx_sample = os_tick && (rx_os_reg == ((rx_state_reg == RX_START) ? OS_HALF : OS_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_reg   <= RX_IDLE;
      rx_os_reg      <= '0;
      rx_bit_reg     <= '0;
      rx_len_reg     <= LEN_MIN;
      rx_buf_reg     <= '0;
      rx_data_reg    <= '0;
      rx_par_en_reg  <= 1'b0;
      rx_par_odd_reg <= 1'b0;
      rx_par_bit_reg <= 1'b0;
      rx_valid_reg   <= 1'b0;
      rx_perr_reg    <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (rx_valid_reg && rx_ready) begin
        rx_valid_reg   <= 1'b0;
        rx_overrun_reg <= 1'b0;
      end
      if (rx_state_reg != RX_IDLE && rx_state_reg != RX_BREAK_WAIT && os_tick)
        rx_os_reg <= rx_sample ? '0 : rx_os_reg + 1'b1;
      case (rx_state_reg)
        RX_IDLE: if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_reg   <= RX_START;
          rx_os_reg      <= '0;
          rx_bit_reg     <= '0;
          rx_buf_reg     <= '0;
          rx_len_reg     <= clamp_len(cfg_len, DATA_W);
          rx_par_en_reg  <= cfg_par_en;
          rx_par_odd_reg <= cfg_par_odd;
        end
        RX_START: if (rx_sample) rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
        RX_DATA: if (rx_sample) begin
          rx_buf_reg <= rx_buf_reg | (DATA_W'(rx_sync_reg) << rx_bit_reg);
          if (rx_bit_reg == rx_len_reg - 4'd1)
            rx_state_reg <= rx_par_en_reg ? RX_PARITY : RX_STOP;
          else
            rx_bit_reg <= rx_bit_reg + 4'd1;
        end
        RX_PARITY: if (rx_sample) begin
          rx_par_bit_reg <= rx_sync_reg;
          rx_state_reg   <= RX_STOP;
        end
        RX_STOP: if (rx_sample) begin
          if (!rx_valid_reg || rx_ready) begin
            rx_valid_reg <= 1'b1;
            rx_data_reg  <= rx_buf_reg;
            rx_ferr_reg  <= ~rx_sync_reg;
            rx_perr_reg  <= rx_par_en_reg &&
                            (parity(16'(rx_buf_reg), rx_len_reg, rx_par_odd_reg) != rx_par_bit_reg);
          end else begin
            rx_overrun_reg <= 1'b1;
          end
          // A break holds the line low; wait for it to rise before re-arming.
          rx_state_reg <= (rx_buf_reg == '0 && !rx_sync_reg) ? RX_BREAK_WAIT : RX_IDLE;
        end
        RX_BREAK_WAIT: if (rx_sync_reg) rx_state_reg <= RX_IDLE;
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid      = rx_valid_reg;
  assign rx_data       = rx_data_reg;
  assign rx_parity_err = rx_perr_reg;
  assign rx_frame_err  = rx_ferr_reg;
  assign rx_overrun    = rx_overrun_reg;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: loopback and externally driven frames,
// false start, framing/break, overrun and mid-frame reset.
module tb_uart_core;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic        clk, rst;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_len;
  logic        cfg_par_en, cfg_par_odd, cfg_stop2, cfg_loopback;
  logic        tx_valid, tx_ready, tx_busy, txd, rxd;
  logic [7:0]  tx_data, rx_data;
  logic        rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_rx   = 0;
  exp_t sb[$];

  uart_core #(.DATA_W(8), .DIV_W(16), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_len(cfg_len),
    .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .cfg_loopback(cfg_loopback), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_busy(tx_busy), .txd(txd), .rxd(rxd),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [7:0] mask(input int len);
    logic [8:0] m;
    m = (9'd1 << len) - 9'd1;
    return m[7:0];
  endfunction

  // Reference parity: count of ones over the frame's data bits, odd/even rule.
  function automatic logic ref_par(input logic [7:0] d, input int len, input logic odd);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(d[i]);
    return logic'(ones % 2) ^ odd;
  endfunction

  function automatic int eff_len(input int l);
    return (l < 5) ? 5 : ((l > 8) ? 8 : l);
  endfunction

  // Monitor: inputs settle right after the negedge, so sampling at negedge+1
  // sees exactly what the DUT will see at the next rising edge.
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #1;
    if (rst && rx_valid && rx_ready) begin
      n_rx++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected actual data=%h pe=%b fe=%b required none", rx_data, rx_parity_err, rx_frame_err);
      end else begin
        e = sb.pop_front();
        $display("rx %0d data=%h pe=%b fe=%b expected data=%h pe=%b fe=%b",
                 n_rx, rx_data, rx_parity_err, rx_frame_err, e.d, e.pe, e.fe);
        chk("rx_data", 32'(rx_data), 32'(e.d));
        chk("rx_parity_err", 32'(rx_parity_err), 32'(e.pe));
        chk("rx_frame_err", 32'(rx_frame_err), 32'(e.fe));
      end
    end
  end

  task automatic send_tx(input logic [7:0] d, output int acc);
    int n = 0;
    while (!tx_ready && n < 3000) begin @(negedge clk); n++; end
    if (!tx_ready) begin
      checks++; errors++;
      $display("FAIL tx_ready_timeout actual=0 required=1");
    end
    tx_data  = d;
    tx_valid = 1'b1;
    acc      = cyc + 1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(tx_ready && sb.size() == 0) && n < 8000) begin @(negedge clk); n++; end
    checks++;
    if (!(tx_ready && sb.size() == 0)) begin
      errors++;
      $display("FAIL idle_timeout actual pending=%0d tx_ready=%b required pending=0 tx_ready=1", sb.size(), tx_ready);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input int len, input logic par_en,
                             input logic par_bit, input logic stop_bit, input int bc);
    rxd = 1'b0; repeat (bc) @(negedge clk);
    for (int i = 0; i < len; i++) begin rxd = d[i]; repeat (bc) @(negedge clk); end
    if (par_en) begin rxd = par_bit; repeat (bc) @(negedge clk); end
    rxd = stop_bit; repeat (bc) @(negedge clk);
    rxd = 1'b1; repeat (bc) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int acc, rx_t, tr_t, n, base, lc, le, bc;
    logic [7:0] d;
    logic corrupt, eb;

    rst = 1'b0; cfg_div = '0; cfg_len = 4'd8; cfg_par_en = 0; cfg_par_odd = 0;
    cfg_stop2 = 0; cfg_loopback = 0; tx_valid = 0; tx_data = '0; rxd = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_errs", {29'd0, rx_parity_err, rx_frame_err, rx_overrun}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 8N1 0xA5 with latency measurement
    cfg_loopback = 1;
    sb.push_back('{8'hA5, 1'b0, 1'b0});
    send_tx(8'hA5, acc);
    chk("t1_txd_held_high", 32'(txd), 32'd1);
    rx_t = -1; tr_t = -1;
    for (int i = 0; i < 400 && (rx_t < 0 || tr_t < 0); i++) begin
      @(negedge clk);
      if (rx_t < 0 && rx_valid) rx_t = cyc - acc;
      if (tr_t < 0 && tx_ready) tr_t = cyc - acc;
    end
    chk_range("t1_rx_latency", rx_t, 152, 168);
    chk("t1_tx_ready_cycles", 32'(tr_t), 32'd160);
    wait_idle();

    // External 7E1, good then bad parity
    cfg_loopback = 0; cfg_len = 4'd7; cfg_par_en = 1; cfg_par_odd = 0;
    sb.push_back('{8'h55, 1'b0, 1'b0});
    drive_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 16);
    sb.push_back('{8'h55, 1'b1, 1'b0});
    drive_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 16);
    wait_idle();

    // False start then valid frame
    cfg_len = 4'd8; cfg_par_en = 0;
    base = n_rx;
    rxd = 1'b0; repeat (4) @(negedge clk);
    rxd = 1'b1; repeat (40) @(negedge clk);
    chk("t3_no_false_frame", 32'(n_rx - base), 32'd0);
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    drive_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 16);
    wait_idle();

    // Framing error, then break held for 30 bit times
    sb.push_back('{8'h81, 1'b0, 1'b1});
    drive_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 16);
    wait_idle();
    base = n_rx;
    sb.push_back('{8'h00, 1'b0, 1'b1});
    rxd = 1'b0; repeat (30 * 16) @(negedge clk);
    chk("t4_break_frames_low", 32'(n_rx - base), 32'd1);
    rxd = 1'b1; repeat (64) @(negedge clk);
    chk("t4_break_frames_after", 32'(n_rx - base), 32'd1);

    // Overrun with consumer stalled
    cfg_loopback = 1; rx_ready = 1'b0;
    sb.push_back('{8'h11, 1'b0, 1'b0});
    send_tx(8'h11, acc);
    send_tx(8'h22, acc);
    n = 0;
    while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("t5_rx_valid", 32'(rx_valid), 32'd1);
    chk("t5_rx_data_held", 32'(rx_data), 32'h11);
    chk("t5_overrun_set", 32'(rx_overrun), 32'd1);
    rx_ready = 1'b1; @(negedge clk);
    rx_ready = 1'b0; @(negedge clk);
    chk("t5_rx_valid_clr", 32'(rx_valid), 32'd0);
    chk("t5_overrun_clr", 32'(rx_overrun), 32'd0);
    rx_ready = 1'b1;
    wait_idle();

    // Random loopback frames across lengths, parity, stop bits and divisors
    for (int k = 0; k < 12; k++) begin
      lc = int'($urandom_range(0, 15)); le = eff_len(lc);
      cfg_len = 4'(lc); cfg_div = 16'($urandom_range(0, 2));
      cfg_par_en = 1'($urandom_range(0, 1)); cfg_par_odd = 1'($urandom_range(0, 1));
      cfg_stop2 = 1'($urandom_range(0, 1)); cfg_loopback = 1;
      d = 8'($urandom);
      sb.push_back('{d & mask(le), 1'b0, 1'b0});
      send_tx(d, acc);
      wait_idle();
    end

    // Random external frames with optional parity corruption
    cfg_loopback = 0; cfg_stop2 = 0; cfg_par_en = 1;
    for (int k = 0; k < 6; k++) begin
      lc = int'($urandom_range(0, 15)); le = eff_len(lc);
      cfg_len = 4'(lc); cfg_div = 16'($urandom_range(0, 1));
      cfg_par_odd = 1'($urandom_range(0, 1));
      bc = (int'(cfg_div) + 1) * 16;
      d = 8'($urandom) & mask(le);
      corrupt = 1'($urandom_range(0, 1));
      sb.push_back('{d, corrupt, 1'b0});
      drive_frame(d, le, 1'b1, ref_par(d, le, cfg_par_odd) ^ corrupt, 1'b1, bc);
      wait_idle();
    end

    // Reset in the middle of a TX frame
    cfg_div = '0; cfg_len = 4'd8; cfg_par_en = 0; cfg_stop2 = 0;
    send_tx(8'hAA, acc);
    repeat (48) @(negedge clk);
    chk("t6_busy_before_rst", 32'(tx_busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_txd", 32'(txd), 32'd1);
    chk("t6_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("t6_rst_tx_busy", 32'(tx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cfg_div = 16'd3; cfg_stop2 = 1;
    repeat (2) @(negedge clk);
    d = 8'hF0;
    send_tx(d, acc);
    for (int i = 0; i < 11; i++) begin
      n = 0;
      while ((cyc - acc) < 32 + 64 * i && n < 2000) begin @(negedge clk); n++; end
      eb = (i == 0) ? 1'b0 : ((i <= 8) ? d[i-1] : 1'b1);
      chk($sformatf("t6_txd_bit%0d", i), 32'(txd), 32'(eb));
    end
    n = 0;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    chk_range("t6_frame_cycles", cyc - acc, 701, 704);
    chk("t6_no_rx", 32'(sb.size() + n_rx - n_rx), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
